// File: rtl/fifo_burst_reader.sv
// Pulls beats one at a time from a FIFO read port and re-emits them with burst framing.
// A burst closes at BurstLen beats, on flush, or when no follow-on beat arrives within Timeout idle cycles.
//
// state    | meaning
// ST_EMPTY | ready to take one beat from the FIFO
// ST_HOLD  | beat parked in hold_q; deciding whether it ends the burst
// ST_OUT   | beat presented downstream, waiting for m_ready_i
module fifo_burst_reader #(
  parameter int DataWidth = 4,
  parameter int BurstLen  = 4,
  parameter int Timeout   = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic                 rvalid_i,
  output logic                 rready_o,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 flush_i,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic [DataWidth-1:0] m_data_o,
  output logic                 m_last_o,
  output logic [15:0]          burst_cnt_o
);

  localparam logic [7:0] BurstLenC = 8'(BurstLen);
  localparam logic [7:0] TimeoutC  = 8'(Timeout);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HOLD  = 2'd1,
    ST_OUT   = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [DataWidth-1:0] hold_q, hold_d;
  logic [7:0]           beat_cnt_q, beat_cnt_d;
  logic [7:0]           tmr_q, tmr_d;
  logic                 last_q, last_d;
  logic [15:0]          burst_cnt_q, burst_cnt_d;
  // Keeps rready_o low until the first clock edge after reset release.
  logic                 armed_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= ST_EMPTY;
      hold_q      <= '0;
      beat_cnt_q  <= '0;
      tmr_q       <= '0;
      last_q      <= 1'b0;
      burst_cnt_q <= '0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      beat_cnt_q  <= beat_cnt_d;
      tmr_q       <= tmr_d;
      last_q      <= last_d;
      burst_cnt_q <= burst_cnt_d;
      armed_q     <= 1'b1;
    end
  end

  assign rready_o    = (state_q == ST_EMPTY) && armed_q;
  assign m_valid_o   = (state_q == ST_OUT);
  assign m_data_o    = m_valid_o ? hold_q : '0;
  assign m_last_o    = m_valid_o && last_q;
  assign burst_cnt_o = burst_cnt_q;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    beat_cnt_d  = beat_cnt_q;
    tmr_d       = tmr_q;
    last_d      = last_q;
    burst_cnt_d = burst_cnt_q;

    unique case (state_q)
      ST_EMPTY: begin
        if (rvalid_i && rready_o) begin
          hold_d     = data_i;
          beat_cnt_d = beat_cnt_q + 8'd1;
          tmr_d      = '0;
          state_d    = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // Priority: full burst, flush, waiting successor, then idle timeout.
        if (beat_cnt_q == BurstLenC) begin
          last_d  = 1'b1;
          state_d = ST_OUT;
        end else if (flush_i) begin
          last_d  = 1'b1;
          state_d = ST_OUT;
        end else if (rvalid_i) begin
          last_d  = 1'b0;
          state_d = ST_OUT;
        end else if (tmr_q == TimeoutC) begin
          last_d  = 1'b1;
          state_d = ST_OUT;
        end else begin
          tmr_d = tmr_q + 8'd1;
        end
      end
      ST_OUT: begin
        if (m_ready_i) begin
          state_d = ST_EMPTY;
          if (last_q) begin
            beat_cnt_d  = '0;
            burst_cnt_d = burst_cnt_q + 16'd1;
          end
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

endmodule
